// File: rtl/freq_divider_pkg.sv
// Shared constants and helpers for the frequency divider.
//   CLK_FREQ_HZ_DEF / OUT_FREQ_HZ_DEF : board defaults (27 MHz in, 500 Hz out)
//   half_period() : clk cycles per output half-period (truncating)
//   cnt_width()   : counter width for a modulus, never less than 1 bit
package freq_divider_pkg;

    localparam int unsigned CLK_FREQ_HZ_DEF = 27_000_000;
    localparam int unsigned OUT_FREQ_HZ_DEF = 500;

    // Integer division truncates; the output frequency is then clk_hz/(2*result).
    // A zero output frequency yields 0 so the elaboration check rejects it.
    function automatic int unsigned half_period(int unsigned clk_hz, int unsigned out_hz);
        if (out_hz == 0) begin
            return 0;
        end
        return clk_hz / (2 * out_hz);
    endfunction

    // A modulus of 1 still needs a 1-bit register so the vector is never zero-width.
    function automatic int unsigned cnt_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N counter with wrap strobe.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, clears the count
//   count_o : current count, 0..N-1
//   wrap_o  : high while count_o == N-1, i.e. the next edge wraps to 0
module mod_n_counter
    import freq_divider_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned W = cnt_width(N)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] MaxCount = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        wrap_o  = (count_q == MaxCount);
        count_d = wrap_o ? '0 : count_q + W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/freq_divider.sv
// Clock-enable-style frequency divider producing a registered 50% duty square wave.
// slow_clk is an ordinary flop output in the clk domain, not a clock net.
// Ports:
//   clk      : system clock (CLK_FREQ_HZ)
//   rst      : asynchronous active-low reset; clears counter and slow_clk at once
//   slow_clk : divided output, toggles every HALF_PERIOD rising edges of clk
module freq_divider
    import freq_divider_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
    parameter int unsigned OUT_FREQ_HZ = OUT_FREQ_HZ_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic slow_clk
);

    localparam int unsigned HALF_PERIOD = half_period(CLK_FREQ_HZ, OUT_FREQ_HZ);
    localparam int unsigned CNT_W       = cnt_width(HALF_PERIOD);

    if (HALF_PERIOD < 1) begin : g_bad_ratio
        $fatal(1, "freq_divider: HALF_PERIOD must be >= 1 (OUT_FREQ_HZ too high)");
    end

    logic [CNT_W-1:0] count;
    logic             wrap;
    logic             slow_clk_q;
    logic             slow_clk_d;

    mod_n_counter #(
        .N (HALF_PERIOD)
    ) u_counter (
        .clk_i   (clk),
        .rst_ni  (rst),
        .count_o (count),
        .wrap_o  (wrap)
    );

    always_comb begin
        slow_clk_d = slow_clk_q ^ wrap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slow_clk_q <= 1'b0;
        end else begin
            slow_clk_q <= slow_clk_d;
        end
    end

    assign slow_clk = slow_clk_q;

    a_count_range : assert property (@(posedge clk) disable iff (!rst)
        32'(count) < HALF_PERIOD);

    a_toggle_on_wrap : assert property (@(posedge clk) disable iff (!rst)
        (slow_clk_q != $past(slow_clk_q)) |-> $past(wrap));

endmodule

// File: tb/tb_freq_divider.sv
module tb_freq_divider;

    localparam int HP_A   = 5;     // 1000 Hz / (2*100)
    localparam int HP_DEF = 27000; // 27 MHz / (2*500)
    localparam int HP_H1  = 1;     // 1000 Hz / (2*500)
    localparam int HP_ODD = 3;     // 1000 Hz / (2*150), truncated

    logic clk;
    logic rst;
    logic slow_a;
    logic slow_def;
    logic slow_h1;
    logic slow_odd;

    int n_checks = 0;
    int n_fail   = 0;

    freq_divider #(.CLK_FREQ_HZ(1000), .OUT_FREQ_HZ(100)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .slow_clk (slow_a)
    );

    freq_divider dut_def (
        .clk      (clk),
        .rst      (rst),
        .slow_clk (slow_def)
    );

    freq_divider #(.CLK_FREQ_HZ(1000), .OUT_FREQ_HZ(500)) dut_h1 (
        .clk      (clk),
        .rst      (rst),
        .slow_clk (slow_h1)
    );

    freq_divider #(.CLK_FREQ_HZ(1000), .OUT_FREQ_HZ(150)) dut_odd (
        .clk      (clk),
        .rst      (rst),
        .slow_clk (slow_odd)
    );

    // 37-unit period, matching a 27 MHz board clock in ns.
    initial begin
        clk = 1'b0;
        forever begin
            #18 clk = 1'b1;
            #19 clk = 1'b0;
        end
    end

    // After k counted edges the output has completed k/hp half-periods, starting low.
    function automatic logic model_slow(int k, int hp);
        return logic'(((k / hp) % 2) == 1);
    endfunction

    function automatic int model_count(int k, int hp);
        return k % hp;
    endfunction

    task automatic apply_reset(int hold);
        @(negedge clk);
        rst = 1'b0;
        repeat (hold) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        int k;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({slow_a, slow_def, slow_h1, slow_odd} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold_slow: got %b expected 0000",
                         {slow_a, slow_def, slow_h1, slow_odd});
            end
            n_checks++;
            if (int'(dut_a.count) !== 0) begin
                n_fail++;
                $display("FAIL reset_hold_count: got %0d expected 0", dut_a.count);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        k = int'($urandom_range(5, 9));
        repeat (k) @(negedge clk);
        n_checks++;
        if (slow_a !== model_slow(k, HP_A)) begin
            n_fail++;
            $display("FAIL pre_async_slow k=%0d: got %b expected %b", k, slow_a,
                     model_slow(k, HP_A));
        end
        // Assert between edges; outputs must clear without a clock edge.
        #3 rst = 1'b0;
        #1;
        n_checks++;
        if ({slow_a, slow_def, slow_h1, slow_odd} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset_slow: got %b expected 0000",
                     {slow_a, slow_def, slow_h1, slow_odd});
        end
        n_checks++;
        if (int'(dut_a.count) !== 0) begin
            n_fail++;
            $display("FAIL async_reset_count: got %0d expected 0", dut_a.count);
        end
    endtask

    task automatic test_divide_by_10();
        int highs;
        highs = 0;
        apply_reset(int'($urandom_range(1, 4)));
        for (int k = 1; k <= 20 * 2 * HP_A; k++) begin
            @(negedge clk);
            highs += int'(slow_a);
            n_checks++;
            if (slow_a !== model_slow(k, HP_A)) begin
                n_fail++;
                $display("FAIL div10_slow k=%0d: got %b expected %b", k, slow_a,
                         model_slow(k, HP_A));
            end
        end
        n_checks++;
        if (highs !== 20 * HP_A) begin
            n_fail++;
            $display("FAIL div10_high_time: got %0d expected %0d", highs, 20 * HP_A);
        end
    endtask

    task automatic test_defaults();
        int ofs;
        ofs = int'($urandom_range(0, 999));
        apply_reset(2);
        for (int k = 1; k <= 2 * HP_DEF; k++) begin
            @(negedge clk);
            if (k == HP_DEF - 1 || k == HP_DEF || k == 2 * HP_DEF - 1 || k == 2 * HP_DEF
                || (k % 1000) == ofs) begin
                n_checks++;
                if (slow_def !== model_slow(k, HP_DEF)) begin
                    n_fail++;
                    $display("FAIL default_slow k=%0d: got %b expected %b", k, slow_def,
                             model_slow(k, HP_DEF));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int k;
        apply_reset(1);
        k = 2 * HP_A - 2;  // count 3, output high
        repeat (k) @(negedge clk);
        n_checks++;
        if (slow_a !== 1'b1 || int'(dut_a.count) !== model_count(k, HP_A)) begin
            n_fail++;
            $display("FAIL midrst_setup: got slow=%b count=%0d expected slow=1 count=%0d",
                     slow_a, dut_a.count, model_count(k, HP_A));
        end
        #3 rst = 1'b0;
        #1;
        n_checks++;
        if (slow_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_clear: got %b expected 0", slow_a);
        end
        repeat (int'($urandom_range(1, 3))) @(negedge clk);
        rst = 1'b1;
        for (int j = 1; j <= HP_A; j++) begin
            @(negedge clk);
            n_checks++;
            if (slow_a !== model_slow(j, HP_A)) begin
                n_fail++;
                $display("FAIL midrst_restart j=%0d: got %b expected %b", j, slow_a,
                         model_slow(j, HP_A));
            end
        end
    endtask

    task automatic test_half_period_one();
        apply_reset(2);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            n_checks++;
            if (slow_h1 !== model_slow(k, HP_H1)) begin
                n_fail++;
                $display("FAIL hp1_slow k=%0d: got %b expected %b", k, slow_h1,
                         model_slow(k, HP_H1));
            end
        end
    endtask

    task automatic test_odd_ratio();
        apply_reset(2);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            n_checks++;
            if (slow_odd !== model_slow(k, HP_ODD)) begin
                n_fail++;
                $display("FAIL odd_slow k=%0d: got %b expected %b", k, slow_odd,
                         model_slow(k, HP_ODD));
            end
        end
    endtask

    task automatic test_random_resets();
        int k;
        for (int it = 0; it < 8; it++) begin
            apply_reset(int'($urandom_range(1, 3)));
            k = int'($urandom_range(1, 40));
            repeat (k) @(negedge clk);
            n_checks++;
            if ({slow_a, slow_odd, slow_h1} !==
                {model_slow(k, HP_A), model_slow(k, HP_ODD), model_slow(k, HP_H1)}) begin
                n_fail++;
                $display("FAIL rand_slow k=%0d: got %b expected %b", k,
                         {slow_a, slow_odd, slow_h1},
                         {model_slow(k, HP_A), model_slow(k, HP_ODD), model_slow(k, HP_H1)});
            end
            n_checks++;
            if (int'(dut_a.count) !== model_count(k, HP_A)) begin
                n_fail++;
                $display("FAIL rand_count k=%0d: got %0d expected %0d", k, dut_a.count,
                         model_count(k, HP_A));
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_divide_by_10();
        test_mid_reset();
        test_half_period_one();
        test_odd_ratio();
        test_random_resets();
        test_defaults();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
